// File: rtl/studio_keypad_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : studio_keypad_ctrl
//  Purpose  : Converts PS/2 key events into per-pad key state through a
//             runtime-loadable scancode map, stretches short presses to a
//             minimum hold time, and presents the CPU-selected key of each
//             pad on the EF flag lines.
//  Revision : 1.0  initial release
// ============================================================================
module studio_keypad_ctrl #(
   parameter int         NUM_PADS      = 2,
   parameter int         KEYS_PER_PAD  = 16,
   parameter int         MIN_HOLD      = 65536,
   parameter logic [2:0] LATCH_PORT    = 3'd2,
   parameter bit         EF_ACTIVE_LOW = 1'b0
) (
   input  logic                i_clk_sys,
   input  logic                i_reset,
   input  logic [10:0]         i_ps2_key,
   input  logic                i_map_wr,
   input  logic [8:0]          i_map_addr,
   input  logic [6:0]          i_map_data,
   input  logic                i_clear_all,
   input  logic                i_io_out,
   input  logic [2:0]          i_io_n,
   input  logic [7:0]          i_cpu_dout,
   output logic [NUM_PADS-1:0] o_key_ef,
   output logic                o_key_any,
   output logic [3:0]          o_key_latch
);

   // Counter must hold MIN_HOLD itself; keep at least one bit when hold is off.
   localparam int                CW        = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
   localparam logic [CW-1:0]     C_HOLD    = CW'(MIN_HOLD);
   localparam logic [CW-1:0]     C_ONE     = CW'(1);
   localparam logic [NUM_PADS-1:0] C_EF_IDLE = {NUM_PADS{EF_ACTIVE_LOW}};

   // Event pipeline
   logic       r_toggle;
   logic       r_ev1_vld;
   logic [8:0] r_ev1_addr;
   logic       r_ev1_press;
   logic       r_ev2_vld;
   logic       r_ev2_press;

   // Scancode map (no reset: contents survive a core reset)
   logic [6:0] r_map [0:511];
   logic [6:0] r_map_q;

   logic       w_ev_ok;
   logic [1:0] w_pad;
   logic [3:0] w_key;

   logic [3:0] r_latch;
   logic [NUM_PADS-1:0]                   r_ef;
   logic                                  r_any;
   logic [NUM_PADS-1:0][KEYS_PER_PAD-1:0] w_state;
   logic [NUM_PADS-1:0]                   w_sel;
   logic                                  w_unused;

   assign w_unused = &{1'b0, i_cpu_dout[7:4]};

   // Detect toggle changes and capture the map address and press/release flag.
   always_ff @(posedge i_clk_sys or posedge i_reset) begin
      if (i_reset) begin
         r_toggle    <= 1'b0;
         r_ev1_vld   <= 1'b0;
         r_ev1_addr  <= '0;
         r_ev1_press <= 1'b0;
         r_ev2_vld   <= 1'b0;
         r_ev2_press <= 1'b0;
      end else begin
         r_toggle  <= i_ps2_key[10];
         r_ev1_vld <= i_ps2_key[10] ^ r_toggle;
         if (i_ps2_key[10] ^ r_toggle) begin
            r_ev1_addr  <= i_ps2_key[8:0];
            r_ev1_press <= i_ps2_key[9];
         end
         r_ev2_vld   <= r_ev1_vld;
         r_ev2_press <= r_ev1_press;
      end
   end

   // Map RAM: synchronous write, registered read returning the pre-write entry.
   always_ff @(posedge i_clk_sys) begin
      if (i_map_wr)
         r_map[i_map_addr] <= i_map_data;
      r_map_q <= r_map[r_ev1_addr];
   end

   assign w_pad   = r_map_q[5:4];
   assign w_key   = r_map_q[3:0];
   assign w_ev_ok = r_ev2_vld && r_map_q[6]
                    && (32'(w_pad) < NUM_PADS)
                    && (32'(w_key) < KEYS_PER_PAD);

   // Key latch is loaded by a CPU OUT cycle on the configured port.
   always_ff @(posedge i_clk_sys or posedge i_reset) begin
      if (i_reset)
         r_latch <= '0;
      else if (i_io_out && (i_io_n == LATCH_PORT))
         r_latch <= i_cpu_dout[3:0];
   end

   for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
      logic [15:0] w_row16;

      for (genvar k = 0; k < KEYS_PER_PAD; k++) begin : g_key
         logic          r_st;
         logic          r_pend;
         logic [CW-1:0] r_cnt;
         logic          w_hit;

         assign w_hit         = w_ev_ok && (w_pad == 2'(p)) && (w_key == 4'(k));
         assign w_state[p][k] = r_st;

         // Per-key state with hold counter; a release during hold is deferred.
         always_ff @(posedge i_clk_sys or posedge i_reset) begin
            if (i_reset) begin
               r_st   <= 1'b0;
               r_pend <= 1'b0;
               r_cnt  <= '0;
            end else if (i_clear_all) begin
               r_st   <= 1'b0;
               r_pend <= 1'b0;
               r_cnt  <= '0;
            end else if (w_hit && r_ev2_press) begin
               r_st   <= 1'b1;
               r_pend <= 1'b0;
               r_cnt  <= C_HOLD;
            end else if (w_hit) begin
               // A counter at 1 expires this very edge, so release at once.
               if (r_cnt <= C_ONE) begin
                  r_st   <= 1'b0;
                  r_pend <= 1'b0;
                  r_cnt  <= '0;
               end else begin
                  r_pend <= 1'b1;
                  r_cnt  <= r_cnt - C_ONE;
               end
            end else if (r_cnt != '0) begin
               r_cnt <= r_cnt - C_ONE;
               if ((r_cnt == C_ONE) && r_pend) begin
                  r_st   <= 1'b0;
                  r_pend <= 1'b0;
               end
            end
         end
      end

      // Zero-extend the row so any 4-bit latch value indexes safely.
      assign w_row16  = 16'(w_state[p]);
      assign w_sel[p] = (32'(r_latch) < KEYS_PER_PAD) ? w_row16[r_latch] : 1'b0;
   end

   // Registered flag outputs with configurable EF polarity.
   always_ff @(posedge i_clk_sys or posedge i_reset) begin
      if (i_reset) begin
         r_ef  <= C_EF_IDLE;
         r_any <= 1'b0;
      end else begin
         r_ef  <= w_sel ^ C_EF_IDLE;
         r_any <= |w_state;
      end
   end

   assign o_key_ef    = r_ef;
   assign o_key_any   = r_any;
   assign o_key_latch = r_latch;

endmodule
`default_nettype wire

// File: doc/studio_keypad_ctrl.md
Name: studio_keypad_ctrl

Overview:
- Parametrised keypad controller for the 1802 console cores: converts PS/2 key events into per-pad key state and presents the CPU-selected key of each pad on the EF flag lines.
- Generalises the fixed two-pad, 10-key decode:
  - configurable pad count and keys per pad;
  - a runtime-loadable scancode map;
  - a minimum press hold time, so short taps are still seen by the polling firmware;
  - a configurable EF polarity.
- Sits between the HPS PS/2 stream / CPU I/O bus and the cdp1802 EF inputs.

Parameters:
- NUM_PADS, 2, number of keypads (1..4).
- KEYS_PER_PAD, 16, keys per pad (2..16); the key index width KW is 4.
- MIN_HOLD, 65536, minimum press visibility in clk_sys cycles; 0 disables hold.
- LATCH_PORT, 2, 3-bit N value whose OUT cycle loads the key latch.
- EF_ACTIVE_LOW, 0, when 1 the key_ef outputs are inverted.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ps2_key  in  11  {toggle, pressed, extended, code[7:0]}.
- map_wr  in  1  map write strobe.
- map_addr  in  9  {extended, code} map entry address.
- map_data  in  7  {valid, pad[1:0], key[3:0]}.
- clear_all  in  1  synchronous release of all keys (OSD open / focus loss).
- io_out  in  1  CPU OUT cycle strobe.
- io_n  in  3  CPU N lines.
- cpu_dout  in  8  CPU output data.
- key_ef  out  NUM_PADS  per-pad flag: selected key pressed (polarity per EF_ACTIVE_LOW).
- key_any  out  1  any key of any pad pressed (active high).
- key_latch  out  4  currently selected key index.

Behaviour:
- Reset:
  - key_latch = 0;
  - all key states, hold counters and pending-release flags = 0;
  - toggle shadow = 0;
  - key_any = 0;
  - key_ef = all 0 (all 1 if EF_ACTIVE_LOW).
  - Map RAM is not reset. It initialises to all-invalid at configuration and keeps its contents across reset.
- Key latch:
  - When io_out=1 and io_n==LATCH_PORT on a clock edge, key_latch <= cpu_dout[3:0].
  - Other io_n values are ignored.
- Event pipeline:
  - Edge k: a difference between ps2_key[10] and its registered shadow is detected. Shadow updates; map read address {ps2_key[8],ps2_key[7:0]} and the pressed bit are captured.
  - Edge k+1: map entry is valid in the register.
  - Edge k+2: key state updates.
  - Edge k+3: key_ef/key_any update (registered outputs). Total latency is 3 cycles from toggle to output.
  - An event is discarded (no state change) if the entry is invalid, pad >= NUM_PADS, or key >= KEYS_PER_PAD.
- Map write:
  - map_wr writes map_data at map_addr.
  - A write in the same cycle as an event read to the same address returns the old entry (read-before-write).
- Press (per key):
  - state <= 1, counter <= MIN_HOLD, pending <= 0.
  - A press on an already pressed key reloads the counter.
- Release:
  - If counter == 0: state <= 0.
  - Otherwise pending <= 1.
- Counter:
  - Decrements by 1 each cycle while nonzero; saturates at 0.
  - On the cycle the counter reaches 0 with pending=1: state <= 0, pending <= 0.
  - A re-press while pending clears pending and reloads the counter.
  - With MIN_HOLD=0, release is immediate.
- clear_all:
  - Forces all states, counters and pending flags to 0 that edge.
  - Has priority over a simultaneous event state update.
- Output decode:
  - key_ef[p] = state[p][key_latch], or 0 when key_latch >= KEYS_PER_PAD, then inverted if EF_ACTIVE_LOW.
  - key_any = OR of all states.
  - A key_latch change is reflected 1 cycle later.
- Reset asserted mid-pipeline drops any in-flight event.
- Duplicate toggles (two changes in consecutive cycles) are each processed; the pipeline accepts one event per cycle.

Test Plan:
- Reset release with no stimulus -> key_ef=00, key_any=0, key_latch=0; with EF_ACTIVE_LOW=1, key_ef=11.
- Map 0x016 -> {1,0,1}; OUT io_n=2 data 0x01; press 0x16 -> key_ef[0]=1 exactly 3 cycles after the toggle, key_ef[1]=0, key_any=1.
- MIN_HOLD=100: press then release 10 cycles later -> key_ef[0] stays 1 until 100 cycles after the press, then 0; a re-press at cycle 50 extends visibility to cycle 150.
- Map 0x11D -> {1,1,3} with the extended flag set; press code 0x1D with ext=0 -> no change; with ext=1 and key_latch=3 -> key_ef[1]=1.
- Entry with key=12 while KEYS_PER_PAD=10, or OUT io_n=1 with data 0x05 -> state and key_latch unchanged; key_latch=0x0F -> key_ef=00.
- Hold a key and pulse clear_all in the same cycle as a new press event -> all states 0, key_any=0; assert reset mid-hold -> counters cleared and key_ef=00 immediately (async).
